// File: rtl/regfile_pkg.sv
// Shared sizing and index constants for the register file, operand decode and ALU stages.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_if.sv
// Write and read port bundle between the datapath control and the register file.
interface regfile_if;
  import regfile_pkg::*;

  logic  ctrl_writeEnable;
  addr_t ctrl_writeReg;
  data_t data_writeReg;
  addr_t ctrl_readRegA;
  addr_t ctrl_readRegB;
  data_t data_readRegA;
  data_t data_readRegB;

  modport master (
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output data_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    input  data_readRegA,
    input  data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  data_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    output data_readRegA,
    output data_readRegB
  );

endinterface

// File: rtl/regfile_register32.sv
// One architectural register: DATA_WIDTH flops with synchronous active-low clear and load enable.
module register32
  import regfile_pkg::*;
(
  input  logic  clock,
  input  logic  ctrl_reset,
  input  logic  write_en,
  input  data_t data_in,
  output data_t data_out
);

  data_t data_d;
  data_t data_q;

  // Clear wins over a coincident load so a reset cycle never leaves partial state.
  always_comb begin
    data_d = data_q;
    if (!ctrl_reset) begin
      data_d = '0;
    end else if (write_en) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: rtl/regfile.sv
// 32 x 32-bit register file: one write port, two combinational read ports, register 0 reads as zero.
module regfile
  import regfile_pkg::*;
(
  input  logic     clock,
  input  logic     ctrl_reset,
  regfile_if.slave bus
);

  logic [NUM_REGS-1:1] write_sel;
  data_t               reg_q [NUM_REGS];

  // One-hot write select; index 0 has no storage, so writes to it simply vanish.
  always_comb begin
    write_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      write_sel[i] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_WIDTH'(i));
    end
  end

  assign reg_q[REG_ZERO] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
    register32 u_reg (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .write_en   (write_sel[g]),
      .data_in    (bus.data_writeReg),
      .data_out   (reg_q[g])
    );
  end

  // No write bypass: reads see the pre-edge contents of the target register.
  assign bus.data_readRegA = reg_q[bus.ctrl_readRegA];
  assign bus.data_readRegB = reg_q[bus.ctrl_readRegB];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, full write/read, r0, bypass, priority, enable, back-to-back.
module tb_regfile;
  import regfile_pkg::*;

  logic clock;
  logic ctrl_reset;
  int   errors;
  int   checks;

  regfile_if rf_bus ();

  regfile dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (rf_bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input addr_t addr, input data_t data);
    rf_bus.ctrl_writeEnable = 1'b1;
    rf_bus.ctrl_writeReg    = addr;
    rf_bus.data_writeReg    = data;
    step();
    rf_bus.ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    data_t exp;
    ctrl_reset = 1'b0;
    step();
    step();
    exp = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_bus.ctrl_readRegA = addr_t'(i);
      rf_bus.ctrl_readRegB = addr_t'(NUM_REGS - 1 - i);
      #1;
      checks++;
      if (rf_bus.data_readRegA !== exp) begin
        errors++;
        $display("[TB] FAIL reset_a[%0d] got=%h want=%h", i, rf_bus.data_readRegA, exp);
      end
      checks++;
      if (rf_bus.data_readRegB !== exp) begin
        errors++;
        $display("[TB] FAIL reset_b[%0d] got=%h want=%h", NUM_REGS - 1 - i, rf_bus.data_readRegB, exp);
      end
    end
    ctrl_reset = 1'b1;
  endtask

  task automatic test_write_read_all();
    data_t exp_a;
    data_t exp_b;
    int    j;
    for (int i = 1; i < NUM_REGS; i++) begin
      do_write(addr_t'(i), 32'hA500_0000 + 32'(i));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      j = NUM_REGS - 1 - i;
      exp_a = (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i);
      exp_b = (j == 0) ? 32'h0 : 32'hA500_0000 + 32'(j);
      rf_bus.ctrl_readRegA = addr_t'(i);
      rf_bus.ctrl_readRegB = addr_t'(j);
      #1;
      checks++;
      if (rf_bus.data_readRegA !== exp_a) begin
        errors++;
        $display("[TB] FAIL all_a[%0d] got=%h want=%h", i, rf_bus.data_readRegA, exp_a);
      end
      checks++;
      if (rf_bus.data_readRegB !== exp_b) begin
        errors++;
        $display("[TB] FAIL all_b[%0d] got=%h want=%h", j, rf_bus.data_readRegB, exp_b);
      end
    end
  endtask

  task automatic test_reg_zero();
    do_write(5'd0, 32'hFFFF_FFFF);
    rf_bus.ctrl_readRegA = 5'd0;
    rf_bus.ctrl_readRegB = 5'd0;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h0) begin
      errors++;
      $display("[TB] FAIL r0_a got=%h want=%h", rf_bus.data_readRegA, 32'h0);
    end
    checks++;
    if (rf_bus.data_readRegB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL r0_b got=%h want=%h", rf_bus.data_readRegB, 32'h0);
    end
  endtask

  task automatic test_same_cycle();
    do_write(5'd7, 32'h1111_1111);
    rf_bus.ctrl_readRegA    = 5'd7;
    rf_bus.ctrl_writeEnable = 1'b1;
    rf_bus.ctrl_writeReg    = 5'd7;
    rf_bus.data_writeReg    = 32'h2222_2222;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h1111_1111) begin
      errors++;
      $display("[TB] FAIL no_bypass got=%h want=%h", rf_bus.data_readRegA, 32'h1111_1111);
    end
    step();
    rf_bus.ctrl_writeEnable = 1'b0;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h2222_2222) begin
      errors++;
      $display("[TB] FAIL after_edge got=%h want=%h", rf_bus.data_readRegA, 32'h2222_2222);
    end
  endtask

  task automatic test_back_to_back();
    rf_bus.ctrl_readRegA    = 5'd9;
    rf_bus.ctrl_writeEnable = 1'b1;
    rf_bus.ctrl_writeReg    = 5'd9;
    rf_bus.data_writeReg    = 32'h0000_0001;
    step();
    rf_bus.data_writeReg = 32'h0000_0002;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL b2b_1 got=%h want=%h", rf_bus.data_readRegA, 32'h0000_0001);
    end
    step();
    rf_bus.data_writeReg = 32'h0000_0003;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h0000_0002) begin
      errors++;
      $display("[TB] FAIL b2b_2 got=%h want=%h", rf_bus.data_readRegA, 32'h0000_0002);
    end
    step();
    rf_bus.ctrl_writeEnable = 1'b0;
    step();
    checks++;
    if (rf_bus.data_readRegA !== 32'h0000_0003) begin
      errors++;
      $display("[TB] FAIL b2b_last got=%h want=%h", rf_bus.data_readRegA, 32'h0000_0003);
    end
  endtask

  task automatic test_enable_low();
    rf_bus.ctrl_writeEnable = 1'b0;
    rf_bus.ctrl_writeReg    = 5'd5;
    rf_bus.data_writeReg    = 32'h1234_5678;
    step();
    rf_bus.ctrl_readRegA = 5'd5;
    rf_bus.ctrl_readRegB = 5'd5;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'hA500_0005) begin
      errors++;
      $display("[TB] FAIL en_low_a got=%h want=%h", rf_bus.data_readRegA, 32'hA500_0005);
    end
    checks++;
    if (rf_bus.data_readRegB !== 32'hA500_0005) begin
      errors++;
      $display("[TB] FAIL en_low_b got=%h want=%h", rf_bus.data_readRegB, 32'hA500_0005);
    end
  endtask

  task automatic test_reset_priority();
    rf_bus.ctrl_readRegA = 5'd3;
    rf_bus.ctrl_readRegB = 5'd5;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'hA500_0003) begin
      errors++;
      $display("[TB] FAIL prio_pre got=%h want=%h", rf_bus.data_readRegA, 32'hA500_0003);
    end
    ctrl_reset = 1'b0;
    do_write(5'd3, 32'hDEAD_BEEF);
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'h0) begin
      errors++;
      $display("[TB] FAIL prio_r3 got=%h want=%h", rf_bus.data_readRegA, 32'h0);
    end
    checks++;
    if (rf_bus.data_readRegB !== 32'h0) begin
      errors++;
      $display("[TB] FAIL prio_r5 got=%h want=%h", rf_bus.data_readRegB, 32'h0);
    end
    do_write(5'd3, 32'hCAFE_F00D);
    #1;
    checks++;
    if (rf_bus.data_readRegA !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL first_write got=%h want=%h", rf_bus.data_readRegA, 32'hCAFE_F00D);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ctrl_reset              = 1'b0;
    rf_bus.ctrl_writeEnable = 1'b0;
    rf_bus.ctrl_writeReg    = '0;
    rf_bus.data_writeReg    = '0;
    rf_bus.ctrl_readRegA    = '0;
    rf_bus.ctrl_readRegB    = '0;
    test_reset();
    test_write_read_all();
    test_reg_zero();
    test_same_cycle();
    test_back_to_back();
    test_enable_low();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
